// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and constants for the I2S receive path
//
// Purpose: state and channel enums for i2s_rx, the default slot width that
//          i2s_clock_gen also uses, and a helper that maps a WS level to a channel.
// Ports:   none (package).

package i2s_pkg;

    localparam int I2S_SLOT_BITS_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAD   = 2'd2
    } i2s_rx_state_e;

    typedef enum logic {
        LEFT  = 1'b0,
        RIGHT = 1'b1
    } i2s_chan_e;

    function automatic i2s_chan_e chan_of(input logic ws, input logic ws_pol);
        return (ws == ws_pol) ? LEFT : RIGHT;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - parameterized flop chain used as synchronizer / alignment delay
//
// Purpose: DEPTH back-to-back flops per bit. Every bit goes through the same
//          depth, so bits that are related in time stay aligned.
// Ports:
//   clk_i   in   1      clock
//   rst_ni  in   1      asynchronous active-low reset, clears every stage
//   d_i     in   WIDTH  input bits
//   q_o     out  WIDTH  input bits delayed by DEPTH clock edges

module sync_ff #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q_o = r_stage[DEPTH-1];

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S receive deserializer producing stereo pairs on valid/ready
//
// Purpose: oversamples SCK/WS/SD in the clk_i domain, recovers one left and one
//          right two's-complement sample per WS frame and presents them as a pair.
// Ports:
//   clk_i        in   1            system clock (same as i2s_clock_gen)
//   rst_ni       in   1            asynchronous active-low reset
//   sck_i        in   1            bit clock
//   ws_i         in   1            word select
//   sd_i         in   1            serial data from the microphone (asynchronous)
//   left_o       out  SAMPLE_BITS  left sample
//   right_o      out  SAMPLE_BITS  right sample
//   valid_o      out  1            pair available
//   ready_i      in   1            consumer accepts the pair
//   overflow_o   out  1            pulse: unaccepted pair overwritten
//   frame_err_o  out  1            pulse: WS edge before SAMPLE_BITS bits were shifted

module i2s_rx
    import i2s_pkg::*;
#(
    parameter int   SLOT_BITS   = I2S_SLOT_BITS_DEFAULT,
    parameter int   SAMPLE_BITS = 24,
    parameter int   SYNC_STAGES = 2,
    parameter logic WS_POL      = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   sck_i,
    input  logic                   ws_i,
    input  logic                   sd_i,
    output logic [SAMPLE_BITS-1:0] left_o,
    output logic [SAMPLE_BITS-1:0] right_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   overflow_o,
    output logic                   frame_err_o
);

    localparam int CNT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_BITS - 1);

    // SD is synchronized; SCK and WS ride the same chain so all three stay aligned.
    logic [2:0] w_sync_q;
    logic       w_sck_d;
    logic       w_ws_d;
    logic       w_sd_d;

    sync_ff #(
        .WIDTH (3),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    ({sck_i, ws_i, sd_i}),
        .q_o    (w_sync_q)
    );

    assign {w_sck_d, w_ws_d, w_sd_d} = w_sync_q;

    logic                   r_sck_prev;
    logic                   r_ws_last;
    i2s_rx_state_e          r_state;
    i2s_rx_state_e          w_state_next;
    i2s_chan_e              r_chan;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [SAMPLE_BITS-1:0] r_shreg;
    logic [SAMPLE_BITS-1:0] r_left_hold;
    logic [SAMPLE_BITS-1:0] r_right_hold;
    logic                   r_left_ok;
    logic                   r_pair_load;

    logic                   w_rise;
    logic                   w_ws_edge;
    logic                   w_last_bit;
    logic [SAMPLE_BITS-1:0] w_word;

    logic                   w_start;
    logic                   w_shift;
    logic                   w_commit;
    logic                   w_early;

    assign w_rise     = w_sck_d & ~r_sck_prev;
    assign w_ws_edge  = w_rise & (w_ws_d != r_ws_last);
    assign w_last_bit = (r_bit_cnt == LAST_BIT);
    // Keep the low SAMPLE_BITS of {shreg, sd}: older bits fall off the top.
    assign w_word     = SAMPLE_BITS'({r_shreg, w_sd_d});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_ws_edge) w_state_next = SHIFT;
            SHIFT:   if (w_ws_edge) w_state_next = SHIFT;
                     else if (w_commit) w_state_next = PAD;
            PAD:     if (w_ws_edge) w_state_next = SHIFT;
            default: w_state_next = IDLE;
        endcase
    end

    // The rise that carries a WS edge is the previous slot's LSB, so it
    // starts a new word and is never shifted in.
    always_comb begin
        w_start  = 1'b0;
        w_shift  = 1'b0;
        w_commit = 1'b0;
        w_early  = 1'b0;
        case (r_state)
            IDLE: begin
                w_start = w_ws_edge;
            end
            SHIFT: begin
                w_start  = w_ws_edge;
                w_early  = w_ws_edge;
                w_shift  = w_rise & ~w_ws_edge;
                w_commit = w_rise & ~w_ws_edge & w_last_bit;
            end
            PAD: begin
                w_start = w_ws_edge;
            end
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sck_prev <= 1'b0;
            r_ws_last  <= WS_POL;
            r_chan     <= LEFT;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
        end else begin
            r_sck_prev <= w_sck_d;
            if (w_rise) begin
                r_ws_last <= w_ws_d;
            end
            if (w_start) begin
                r_chan    <= chan_of(w_ws_d, WS_POL);
                r_bit_cnt <= '0;
                r_shreg   <= '0;
            end else if (w_shift) begin
                r_shreg <= w_word;
                // Hold at the last bit; PAD absorbs the rest of the slot.
                if (!w_last_bit) begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    // A right word only forms a pair if a left word preceded it in this frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_left_hold  <= '0;
            r_right_hold <= '0;
            r_left_ok    <= 1'b0;
            r_pair_load  <= 1'b0;
        end else begin
            r_pair_load <= 1'b0;
            if (w_early) begin
                r_left_ok <= 1'b0;
            end else if (w_commit) begin
                if (r_chan == LEFT) begin
                    r_left_hold <= w_word;
                    r_left_ok   <= 1'b1;
                end else if (r_left_ok) begin
                    r_right_hold <= w_word;
                    r_pair_load  <= 1'b1;
                    r_left_ok    <= 1'b0;
                end
            end
        end
    end

    // A load overrides a same-cycle transfer; overflow only when the old
    // pair was still pending with no acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            left_o      <= '0;
            right_o     <= '0;
            valid_o     <= 1'b0;
            overflow_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= w_early;
            if (r_pair_load) begin
                left_o     <= r_left_hold;
                right_o    <= r_right_hold;
                valid_o    <= 1'b1;
                overflow_o <= valid_o & ~ready_i;
            end else begin
                overflow_o <= 1'b0;
                if (valid_o && ready_i) begin
                    valid_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// tb/tb_i2s_rx.sv - directed self-checking bench for i2s_rx

module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sck;
    logic        ws;
    logic        sd;
    logic        ready;

    logic [23:0] left_o, right_o, left_p, right_p;
    logic        valid_o, valid_p, ovf, ovf_p, ferr, ferr_p;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    int vrise_cnt = 0;
    int vhigh_cnt = 0;
    int ovf_cnt = 0;
    int ferr_cnt = 0;
    int vrise_cyc = 0;
    logic v_prev = 1'b0;

    int last_rise = 0;
    int data_rise = 0;

    int b_rise, b_high, b_ovf, b_ferr;

    always #5 clk = ~clk;

    i2s_rx #(
        .SLOT_BITS   (32),
        .SAMPLE_BITS (24),
        .SYNC_STAGES (2),
        .WS_POL      (1'b0)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .sck_i       (sck),
        .ws_i        (ws),
        .sd_i        (sd),
        .left_o      (left_o),
        .right_o     (right_o),
        .valid_o     (valid_o),
        .ready_i     (ready),
        .overflow_o  (ovf),
        .frame_err_o (ferr)
    );

    // Same stream with WS inverted: left data now travels while WS is high.
    i2s_rx #(
        .SLOT_BITS   (32),
        .SAMPLE_BITS (24),
        .SYNC_STAGES (2),
        .WS_POL      (1'b1)
    ) dut_p (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .sck_i       (sck),
        .ws_i        (~ws),
        .sd_i        (sd),
        .left_o      (left_p),
        .right_o     (right_p),
        .valid_o     (valid_p),
        .ready_i     (ready),
        .overflow_o  (ovf_p),
        .frame_err_o (ferr_p)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        v_prev <= valid_o;
        if (valid_o) vhigh_cnt <= vhigh_cnt + 1;
        if (valid_o && !v_prev) begin
            vrise_cnt <= vrise_cnt + 1;
            vrise_cyc <= cyc;
        end
        if (ovf) ovf_cnt <= ovf_cnt + 1;
        if (ferr) ferr_cnt <= ferr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One SCK period of 8 clk: data and WS change while SCK is low.
    task automatic send_bit(input logic w, input logic d);
        sck = 1'b0;
        ws  = w;
        sd  = d;
        repeat (4) @(negedge clk);
        sck = 1'b1;
        last_rise = cyc + 1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_slot(input logic w, input logic first, input logic [23:0] word);
        send_bit(w, first);
        for (int i = 0; i < 24; i++) send_bit(w, word[23-i]);
        data_rise = last_rise;
        for (int i = 0; i < 7; i++) send_bit(w, 1'b0);
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send_slot(1'b0, 1'b0, l);
        send_slot(1'b1, 1'b0, r);
    endtask

    initial begin
        rst_n = 1'b0;
        sck   = 1'b0;
        ws    = 1'b0;
        sd    = 1'b0;
        ready = 1'b1;
        repeat (3) @(negedge clk);

        check("reset_valid", valid_o, 0);
        check("reset_left", left_o, 0);
        check("reset_right", right_o, 0);
        check("reset_overflow", ovf, 0);
        check("reset_frame_err", ferr, 0);
        check("reset_left_pol", left_p, 0);

        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // A lone right slot after reset has no left partner.
        send_slot(1'b1, 1'b0, 24'hABCDEF);
        check("preamble_no_valid", vrise_cnt, 0);

        // Basic pair and latency.
        b_rise = vrise_cnt;
        b_high = vhigh_cnt;
        send_frame(24'h7FFFFF, 24'h800001);
        check("basic_left", left_o, 24'h7FFFFF);
        check("basic_right", right_o, 24'h800001);
        check("basic_valid_count", vrise_cnt, b_rise + 1);
        check("basic_valid_width", vhigh_cnt, b_high + 1);
        check("basic_latency", vrise_cyc, data_rise + 3);
        check("pol_left", left_p, 24'h7FFFFF);
        check("pol_right", right_p, 24'h800001);

        // One-bit delay: the edge bit is 1 but must not enter the sample.
        b_rise = vrise_cnt;
        send_slot(1'b0, 1'b1, 24'h000000);
        send_slot(1'b1, 1'b1, 24'h000000);
        check("delay_left", left_o, 24'h000000);
        check("delay_right", right_o, 24'h000000);
        check("delay_valid_count", vrise_cnt, b_rise + 1);

        // Backpressure across two frames.
        ready = 1'b0;
        b_ovf = ovf_cnt;
        send_frame(24'h111111, 24'h222222);
        check("bp_valid_first", valid_o, 1);
        check("bp_left_first", left_o, 24'h111111);
        check("bp_right_first", right_o, 24'h222222);
        send_slot(1'b0, 1'b0, 24'h333333);
        check("bp_left_stable", left_o, 24'h111111);
        check("bp_right_stable", right_o, 24'h222222);
        check("bp_no_overflow_yet", ovf_cnt, b_ovf);
        send_slot(1'b1, 1'b0, 24'h444444);
        check("bp_overflow_pulse", ovf_cnt, b_ovf + 1);
        check("bp_left_new", left_o, 24'h333333);
        check("bp_right_new", right_o, 24'h444444);
        check("bp_valid_held", valid_o, 1);
        ready = 1'b1;
        @(negedge clk);
        check("bp_valid_cleared", valid_o, 0);

        // Early WS edge after 10 bits of a left slot.
        b_rise = vrise_cnt;
        b_ferr = ferr_cnt;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) send_bit(1'b0, i[0]);
        send_slot(1'b1, 1'b0, 24'h123456);
        check("early_frame_err", ferr_cnt, b_ferr + 1);
        check("early_no_valid", vrise_cnt, b_rise);
        send_frame(24'h5A5A5A, 24'hA5A5A5);
        check("early_recover_count", vrise_cnt, b_rise + 1);
        check("early_recover_left", left_o, 24'h5A5A5A);
        check("early_recover_right", right_o, 24'hA5A5A5);
        check("early_single_err", ferr_cnt, b_ferr + 1);

        // Reset during the 12th bit of a left slot.
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 11; i++) send_bit(1'b0, 1'b1);
        sck = 1'b0;
        sd  = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_left", left_o, 0);
        check("rst_right", right_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_left_pol", left_p, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) send_bit(1'b0, 1'b1);
        b_rise = vrise_cnt;
        send_slot(1'b1, 1'b0, 24'h0F0F0F);
        check("rst_partial_ignored", vrise_cnt, b_rise);
        send_frame(24'h654321, 24'h9ABCDE);
        check("rst_recover_count", vrise_cnt, b_rise + 1);
        check("rst_recover_left", left_o, 24'h654321);
        check("rst_recover_right", right_o, 24'h9ABCDE);

        // WS_POL=1 instance sees the same pairing with inverted WS.
        check("pol_left_after_rst", left_p, 24'h654321);
        check("pol_right_after_rst", right_p, 24'h9ABCDE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
